// File: rtl/sobel_seq_pkg.sv
// Shared types and constants for the Sobel result sequencer.
package sobel_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_RESULT  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_FULL      = 3;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_W   = 5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

endpackage

// File: rtl/sobel_seq_fifo.sv
// Synchronous 8-bit result buffer with flush; flush overrides push and pop.
module sobel_seq_fifo #(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sobel_result_sequencer.sv
// Avalon-MM controlled sequencer that enables the Sobel datapath and buffers its results.
//   state | meaning
//   IDLE  | waiting for start; datapath disabled
//   RUN   | go high, accepting results until target count reached
//   DONE  | one-cycle completion state, sets sticky done
module sobel_result_sequencer
  import sobel_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        go,
  input  logic [7:0]  res_data,
  input  logic        res_valid,
  output logic        res_ready,
  output logic        irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] cap_cnt;
  logic               done;
  logic               irq_en;
  logic [31:0]        rd_mux;

  logic               ctrl_wr;
  logic               start_req;
  logic               abort_req;
  logic               handshake;
  logic               last_hs;
  logic               count_zero;
  logic               set_done;
  logic               clr_done;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic [7:0]         fifo_dout;
  logic [LVL_W-1:0]   fifo_level;
  logic               fifo_full;
  logic               fifo_empty;

  logic               unused_wdata;

  assign unused_wdata = ^writedata;

  assign ctrl_wr    = write && (address == ADDR_CONTROL);
  assign abort_req  = ctrl_wr && writedata[CTRL_ABORT];
  assign start_req  = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_ABORT];
  assign count_zero = (count_reg == '0);
  assign handshake  = res_valid && res_ready;
  assign last_hs    = handshake && ((cap_cnt + COUNT_W'(1)) == count_reg);

  // Abort discards everything, including a handshake in the same cycle.
  assign fifo_flush = (state == ST_RUN) && abort_req;
  assign fifo_push  = handshake && !abort_req;
  assign fifo_pop   = read && (address == ADDR_RESULT) && !fifo_empty;

  assign set_done = ((state == ST_IDLE) && start_req && count_zero) || (state == ST_DONE);
  assign clr_done = write && (address == ADDR_STATUS) && writedata[STAT_DONE];

  assign irq = done && irq_en;

  sobel_seq_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (res_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_req && !count_zero) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort_req)    state_nxt = ST_IDLE;
        else if (last_hs) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    go        = (state == ST_RUN);
    res_ready = (state == ST_RUN) && !fifo_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_cnt   <= '0;
      count_reg <= '0;
      done      <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start_req && !count_zero)
        cap_cnt <= '0;
      else if ((state == ST_RUN) && fifo_push)
        cap_cnt <= cap_cnt + COUNT_W'(1);

      if (write && (address == ADDR_COUNT) && (state != ST_RUN))
        count_reg <= writedata[COUNT_W-1:0];

      if (set_done)      done <= 1'b1;
      else if (clr_done) done <= 1'b0;

      if (ctrl_wr) irq_en <= writedata[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_RESULT: if (!fifo_empty) rd_mux[7:0] = fifo_dout;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]                  = (state == ST_RUN);
        rd_mux[STAT_DONE]                  = done;
        rd_mux[STAT_EMPTY]                 = fifo_empty;
        rd_mux[STAT_FULL]                  = fifo_full;
        rd_mux[STAT_LEVEL_LSB +: LVL_W]    = fifo_level;
      end
      ADDR_CONTROL: rd_mux[CTRL_IRQ_EN] = irq_en;
      ADDR_COUNT:   rd_mux[COUNT_W-1:0] = count_reg;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule
